// File: rtl/csa_multiword_seq.sv
// Sequential wide adder: one SLICE_WIDTH carry-skip adder reused over NUM_SLICES cycles, LSB slice first.
// Result is valid NUM_SLICES cycles after accept and held in DONE until OUT_READY; operands are accepted only in IDLE.
module csa_multiword_seq #(
    parameter  int SLICE_WIDTH = 16,
    parameter  int GROUP_SIZE  = 4,
    parameter  int NUM_SLICES  = 4,
    localparam int W           = SLICE_WIDTH * NUM_SLICES
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [W:1]   A,
    input  logic [W:1]   B,
    input  logic         CIN,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [W:1]   SUM,
    output logic         COUT,
    output logic         BUSY
);

    localparam int IDXW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_SLICES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
    typedef logic [NUM_SLICES-1:0][SLICE_WIDTH-1:0] word_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    word_t             a_q, a_d;
    word_t             b_q, b_d;
    word_t             sum_q, sum_d;

    logic [SLICE_WIDTH-1:0] slice_a, slice_b, slice_sum;
    logic                   slice_cout;
    logic                   last_slice;

    assign slice_a    = a_q[idx_q];
    assign slice_b    = b_q[idx_q];
    assign last_slice = (idx_q == IDX_LAST);

    CSA_p #(
        .WIDTH      (SLICE_WIDTH),
        .GROUP_SIZE (GROUP_SIZE)
    ) u_csa (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (IN_VALID)   state_d = ST_RUN;
            ST_RUN:  if (last_slice) state_d = ST_DONE;
            ST_DONE: if (OUT_READY)  state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Datapath: operands are captured once, so port changes after accept cannot leak in.
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        case (state_q)
            ST_IDLE: begin
                if (IN_VALID) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = CIN;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                end
            end
            ST_RUN: begin
                sum_d[idx_q] = slice_sum;
                carry_d      = slice_cout;
                if (last_slice) begin
                    cout_d = slice_cout;
                    idx_d  = '0;
                end else begin
                    idx_d  = idx_q + IDXW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        IN_READY  = (state_q == ST_IDLE);
        OUT_VALID = (state_q == ST_DONE);
        BUSY      = (state_q != ST_IDLE);
        SUM       = sum_q;
        COUT      = cout_q;
    end

endmodule

// Carry-skip adder: ripple inside each group, group carry bypassed when every bit of the group propagates.
module CSA_p #(
    parameter int WIDTH      = 16,
    parameter int GROUP_SIZE = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NUM_GROUPS = WIDTH / GROUP_SIZE;

    always_comb begin
        logic c;
        logic rc;
        logic grp_p;
        logic p;
        c     = cin;
        rc    = 1'b0;
        grp_p = 1'b0;
        p     = 1'b0;
        sum   = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            rc    = c;
            grp_p = 1'b1;
            for (int i = 0; i < GROUP_SIZE; i++) begin
                p                    = a[g*GROUP_SIZE+i] ^ b[g*GROUP_SIZE+i];
                sum[g*GROUP_SIZE+i]  = p ^ rc;
                rc                   = (a[g*GROUP_SIZE+i] & b[g*GROUP_SIZE+i]) | (p & rc);
                grp_p                = grp_p & p;
            end
            c = grp_p ? c : rc;
        end
        cout = c;
    end

endmodule

// File: tb/tb_csa_multiword_seq.sv
// Bench for csa_multiword_seq: directed corner cases on a 4-slice instance, then random soak on 4-slice and 1-slice instances.
module tb_csa_multiword_seq;

    logic core_clk = 1'b0;
    logic rst;

    logic [1:0]       in_vld, in_rdy, cin, out_vld, out_rdy, cout, busy;
    logic [1:0][64:1] a, b, sum;

    int n_cmp = 0;
    int n_err = 0;

    always #5 core_clk = ~core_clk;

    csa_multiword_seq #(.SLICE_WIDTH(16), .GROUP_SIZE(4), .NUM_SLICES(4)) u_dut4 (
        .CLK(core_clk), .RST(rst), .IN_VALID(in_vld[0]), .IN_READY(in_rdy[0]),
        .A(a[0]), .B(b[0]), .CIN(cin[0]), .OUT_VALID(out_vld[0]), .OUT_READY(out_rdy[0]),
        .SUM(sum[0]), .COUT(cout[0]), .BUSY(busy[0])
    );

    csa_multiword_seq #(.SLICE_WIDTH(64), .GROUP_SIZE(4), .NUM_SLICES(1)) u_dut1 (
        .CLK(core_clk), .RST(rst), .IN_VALID(in_vld[1]), .IN_READY(in_rdy[1]),
        .A(a[1]), .B(b[1]), .CIN(cin[1]), .OUT_VALID(out_vld[1]), .OUT_READY(out_rdy[1]),
        .SUM(sum[1]), .COUT(cout[1]), .BUSY(busy[1])
    );

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain 65-bit integer addition.
    function automatic logic [64:0] ref_add(input logic [64:1] x, input logic [64:1] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {64'b0, c};
    endfunction

    function automatic logic [64:1] rnd_op();
        case ($urandom_range(0, 5))
            0:       return '1;
            1:       return '0;
            2:       return {32'hFFFF_FFFF, $urandom()};
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // Presents operands and returns at the negedge just after the accepting edge.
    task automatic send(input int d, input logic [64:1] av, input logic [64:1] bv, input logic cv);
        @(negedge core_clk);
        a[d]      = av;
        b[d]      = bv;
        cin[d]    = cv;
        in_vld[d] = 1'b1;
        chk("acc_rdy", 65'(in_rdy[d]), 65'd1);
        @(negedge core_clk);
        in_vld[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, output int lat);
        lat = 0;
        while (!out_vld[d] && lat < 20) begin
            @(negedge core_clk);
            lat++;
        end
    endtask

    task automatic release_out(input int d);
        out_rdy[d] = 1'b1;
        @(negedge core_clk);
        out_rdy[d] = 1'b0;
        chk("rel_rdy",  65'(in_rdy[d]),  65'd1);
        chk("rel_vld",  65'(out_vld[d]), 65'd0);
        chk("rel_busy", 65'(busy[d]),    65'd0);
    endtask

    task automatic soak(input int d, input int n_ops);
        logic [64:0] exp_q[$];
        int sent  = 0;
        int got   = 0;
        int stall = 0;
        bit fresh = 1'b1;
        while (got < n_ops && stall < 200) begin
            @(negedge core_clk);
            if (fresh) begin
                fresh = 1'b0;
                if (sent < n_ops) begin
                    a[d]      = rnd_op();
                    b[d]      = rnd_op();
                    cin[d]    = 1'($urandom_range(0, 1));
                    in_vld[d] = 1'b1;
                end else begin
                    in_vld[d] = 1'b0;
                end
            end
            out_rdy[d] = ($urandom_range(0, 3) != 0);
            if (in_vld[d] && in_rdy[d]) begin
                exp_q.push_back(ref_add(a[d], b[d], cin[d]));
                sent++;
                fresh = 1'b1;
            end
            if (out_vld[d] && out_rdy[d]) begin
                chk("soak_extra", 65'(exp_q.size() == 0), 65'd0);
                if (exp_q.size() != 0) chk("soak_sum", {cout[d], sum[d]}, exp_q.pop_front());
                got++;
                stall = 0;
            end else begin
                stall++;
            end
        end
        in_vld[d]  = 1'b0;
        out_rdy[d] = 1'b0;
        chk("soak_count", 65'(got), 65'(n_ops));
        chk("soak_left",  65'(exp_q.size()), 65'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        logic [64:1] ra, rb;
        logic        rc;

        rst     = 1'b1;
        in_vld  = '0;
        out_rdy = '0;
        a       = '0;
        b       = '0;
        cin     = '0;
        @(negedge core_clk);
        @(negedge core_clk);
        chk("rst_in_rdy", 65'(in_rdy[0]),  65'd1);
        chk("rst_out_vld", 65'(out_vld[0]), 65'd0);
        chk("rst_busy",   65'(busy[0]),    65'd0);
        chk("rst_sum",    {cout[0], sum[0]}, 65'd0);
        rst = 1'b0;

        // Full ripple across every slice.
        send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        wait_done(0, lat);
        chk("t1_lat",  65'(lat), 65'd4);
        chk("t1_res",  {cout[0], sum[0]}, {1'b1, 64'h0});
        chk("t1_busy", 65'(busy[0]),   65'd1);
        chk("t1_rdy",  65'(in_rdy[0]), 65'd0);
        release_out(0);

        // Slice-boundary carry, then held result under backpressure with a pending producer.
        send(0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        wait_done(0, lat);
        chk("t2_lat", 65'(lat), 65'd4);
        chk("t2_res", {cout[0], sum[0]}, {1'b0, 64'h0000_0000_0001_0000});
        a[0]      = 64'hDEAD_BEEF_0000_0001;
        b[0]      = 64'h5;
        in_vld[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge core_clk);
            chk("bp_res", {cout[0], sum[0]}, {1'b0, 64'h0000_0000_0001_0000});
            chk("bp_vld", 65'(out_vld[0]), 65'd1);
            chk("bp_rdy", 65'(in_rdy[0]),  65'd0);
        end
        out_rdy[0] = 1'b1;
        @(negedge core_clk);
        out_rdy[0] = 1'b0;
        in_vld[0]  = 1'b0;
        chk("bp_rel_rdy",  65'(in_rdy[0]),  65'd1);
        chk("bp_rel_busy", 65'(busy[0]),    65'd0);
        chk("bp_rel_vld",  65'(out_vld[0]), 65'd0);

        // Operand ports change after accept.
        send(0, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
        a[0]   = 64'h0;
        b[0]   = 64'h0;
        cin[0] = 1'b1;
        wait_done(0, lat);
        chk("t5_lat", 65'(lat), 65'd4);
        chk("t5_res", {cout[0], sum[0]}, {1'b0, 64'h2345_6789_ABCD_F001});
        release_out(0);

        // Reset while slice index 2 is being processed.
        send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        @(negedge core_clk);
        @(negedge core_clk);
        rst = 1'b1;
        @(negedge core_clk);
        rst = 1'b0;
        chk("t4_rdy",  65'(in_rdy[0]),  65'd1);
        chk("t4_vld",  65'(out_vld[0]), 65'd0);
        chk("t4_busy", 65'(busy[0]),    65'd0);
        chk("t4_sum",  {cout[0], sum[0]}, 65'd0);
        seen = 0;
        out_rdy[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge core_clk);
            if (out_vld[0]) seen++;
        end
        out_rdy[0] = 1'b0;
        chk("t4_no_result", 65'(seen), 65'd0);

        // Single-slice instance completes one cycle after accept.
        ra = {$urandom(), $urandom()};
        rb = {$urandom(), $urandom()};
        rc = 1'($urandom_range(0, 1));
        send(1, ra, rb, rc);
        wait_done(1, lat);
        chk("n1_lat", 65'(lat), 65'd1);
        chk("n1_res", {cout[1], sum[1]}, ref_add(ra, rb, rc));
        release_out(1);

        fork
            soak(0, 4000);
            soak(1, 4000);
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
